// File: rtl/rot_share_arb_2ch_pkg.sv
// rtl/rot_share_arb_2ch_pkg.sv - shared constants for the two-channel rotate arbiter
package rot_share_arb_2ch_pkg;

   localparam int DATA_W = 32;
   localparam int AMT_W  = 5;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   localparam logic SRC_CH0 = 1'b0;
   localparam logic SRC_CH1 = 1'b1;

endpackage

// File: rtl/rot_share_arb_2ch_rotr.sv
// rtl/rot_share_arb_2ch_rotr.sv - combinational 32-bit right rotate, 5-stage log shifter
module rot_share_arb_2ch_rotr
   import rot_share_arb_2ch_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [AMT_W-1:0]  amt,
   output logic [DATA_W-1:0] y
);

   logic [DATA_W-1:0] s1, s2, s3, s4;

   // Each stage rotates right by 2^k when amount bit k is set: y[i] = a[(i+amt) mod 32]
   always_comb begin
      s1 = amt[0] ? {a[0],      a[31:1]}   : a;
      s2 = amt[1] ? {s1[1:0],   s1[31:2]}  : s1;
      s3 = amt[2] ? {s2[3:0],   s2[31:4]}  : s2;
      s4 = amt[3] ? {s3[7:0],   s3[31:8]}  : s3;
      y  = amt[4] ? {s4[15:0],  s4[31:16]} : s4;
   end

endmodule

// File: rtl/rot_share_arb_2ch_rr_arb_2.sv
// rtl/rot_share_arb_2ch_rr_arb_2.sv - two-way round-robin arbiter with priority pointer
module rr_arb_2
   import rot_share_arb_2ch_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       free,
   output logic [1:0] gnt,
   output logic       winner
);

   logic ptr_q, ptr_d;

   // Winner select: a lone requester wins, contention goes to the pointer; grant only when free
   always_comb begin
      winner = SRC_CH0;
      case (req)
         2'b01:   winner = SRC_CH0;
         2'b10:   winner = SRC_CH1;
         2'b11:   winner = ptr_q;
         default: winner = SRC_CH0;
      endcase
      gnt    = 2'b00;
      gnt[0] = free & req[0] & (winner == SRC_CH0);
      gnt[1] = free & req[1] & (winner == SRC_CH1);
      ptr_d  = ptr_q;
      if (|gnt) begin
         ptr_d = ~winner;
      end
   end

   // Pointer register: favours channel 0 out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= SRC_CH0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rot_share_arb_2ch.sv
// rtl/rot_share_arb_2ch.sv - two channels sharing one right-rotate datapath with registered output
module rot_share_arb_2ch
   import rot_share_arb_2ch_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [AMT_W-1:0]  req0_amt,
   input  logic              req0_left,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [AMT_W-1:0]  req1_amt,
   input  logic              req1_left,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_y,
   output logic              out_src,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1
);

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] y_q;
   logic              src_q;
   logic [CNT_W-1:0]  cnt0_q, cnt1_q;

   logic              free;
   logic              accept;
   logic [1:0]        gnt;
   logic              winner;
   logic [DATA_W-1:0] sel_a;
   logic [AMT_W-1:0]  sel_amt;
   logic              sel_left;
   logic [AMT_W-1:0]  eff_amt;
   logic [DATA_W-1:0] rot_y;

   assign free = (state_q == ST_EMPTY) || out_ready;

   rr_arb_2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({req1_valid, req0_valid}),
      .free   (free),
      .gnt    (gnt),
      .winner (winner)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign accept     = |gnt;

   // Steer the winning operand into the shared datapath; left rotates become negated right amounts
   always_comb begin
      sel_a    = (winner == SRC_CH1) ? req1_a    : req0_a;
      sel_amt  = (winner == SRC_CH1) ? req1_amt  : req0_amt;
      sel_left = (winner == SRC_CH1) ? req1_left : req0_left;
      eff_amt  = (sel_left == DIR_LEFT) ? ('0 - sel_amt) : sel_amt;
   end

   rot_share_arb_2ch_rotr u_rotr (
      .a   (sel_a),
      .amt (eff_amt),
      .y   (rot_y)
   );

   // Output occupancy: EMPTY fills on a grant, FULL drains when consumed with nothing new
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Result register loads only on an accepted request, so back-pressure holds it stable
   always_ff @(posedge clk) begin
      if (reset) begin
         y_q   <= '0;
         src_q <= SRC_CH0;
      end else if (accept) begin
         y_q   <= rot_y;
         src_q <= winner;
      end
   end

   // Per-channel grant counters that stick at all-ones
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt[0] && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
         if (gnt[1] && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_y     = y_q;
   assign out_src   = src_q;
   assign gnt_cnt0  = cnt0_q;
   assign gnt_cnt1  = cnt1_q;

endmodule
